uart_loader: RTL and testbench

Downstream consumer of the UART receiver: takes its byte stream over a valid/ready handshake, parses a simple boot-load frame (sync byte, little-endian word count, payload, optional checksum), and writes the payload as 32-bit words to memory through a valid/ready write port. It sits between the UART receive path and the instruction/data RAM write mux. It lets the SoC be loaded over the serial link without reprogramming the FPGA.

---
 rtl/uart_loader_pkg.sv | 19 +
 rtl/uart_loader_if.sv | 23 ++
 rtl/uart_loader_packer.sv | 39 +++
 rtl/uart_loader.sv | 154 +++++++++++++++
 tb/tb_uart_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial boot loader.
// The checksum state is only reachable when UART_LOADER_CHECKSUM_EN is defined.
package uart_loader_pkg;

    localparam int unsigned LEN_BYTES         = 4;
    localparam int unsigned WORD_BYTES        = 4;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/uart_loader_if.sv
// Byte stream from the UART receiver plus the memory write port of the loader.
// master: the loader side; slave: the UART/memory environment side.
interface uart_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_valid;
    logic                  mem_ready;

    modport master (
        input  rx_data, rx_valid, mem_ready,
        output rx_ready, mem_addr, mem_wdata, mem_valid
    );

    modport slave (
        output rx_data, rx_valid, mem_ready,
        input  rx_ready, mem_addr, mem_wdata, mem_valid
    );
endinterface

// File: rtl/uart_loader_packer.sv
// Little-endian byte-to-word shift register; first loaded byte ends up in [7:0].
// full flags the load that completes a word; next_word previews the word after this load.
module uart_loader_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] next_word,
    output logic        full
);

    localparam int unsigned IdxW = $clog2(WORD_BYTES);

    logic [IdxW-1:0] idx_q;
    logic [31:0]     word_q;

    assign next_word = {byte_in, word_q[31:8]};
    assign full      = load && (idx_q == IdxW'(WORD_BYTES - 1));
    assign word      = word_q;

    // Index wraps naturally, so LEN and DATA can share this register back to back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load) begin
            idx_q  <= idx_q + 1'b1;
            word_q <= next_word;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot-load frame parser: sync byte, LE word count, payload words written to memory.
// Define UART_LOADER_CHECKSUM_EN to require a trailing 8-bit additive checksum byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           MAX_WORDS      = 4096,
    parameter logic [7:0]            SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned           TIMEOUT_CYCLES = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    uart_loader_if.master      bus,
    input  logic               clr,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [31:0]        words_written
);

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_e StEnd = StCsum;
`else
    localparam state_e StEnd = StDone;
`endif

    state_e                state_q, state_d;
    logic                  rx_ready_q, mem_valid_q, busy_q, done_q, error_q;
    logic [31:0]           count_q, words_q, tmo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           pk_word, pk_next;
    logic                  pk_full, pk_clear, pk_load;
    logic                  accept, is_sync, timed_out, last_word, counting;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign is_sync   = bus.rx_data == SYNC_BYTE;
    assign pk_clear  = (state_q == StIdle) && accept && is_sync;
    assign pk_load   = accept && ((state_q == StLen) || (state_q == StData));
    assign counting  = state_q inside {StLen, StData, StCsum};
    assign timed_out = tmo_q == 32'(TIMEOUT_CYCLES - 1);
    assign last_word = (words_q + 32'd1) == count_q;

    uart_loader_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .byte_in   (bus.rx_data),
        .word      (pk_word),
        .next_word (pk_next),
        .full      (pk_full)
    );

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (pk_clear) begin
            sum_q <= '0;
        end else if (pk_load) begin
            sum_q <= sum_q + bus.rx_data;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && is_sync) state_d = StLen;
            end
            StLen: begin
                if (accept) begin
                    if (pk_full) begin
                        if (pk_next > MAX_WORDS) state_d = StError;
                        else if (pk_next == '0)  state_d = StEnd;
                        else                     state_d = StData;
                    end
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (accept) begin
                    if (pk_full) state_d = StWrite;
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StWrite: begin
                if (bus.mem_ready) state_d = last_word ? StEnd : StData;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept)         state_d = (bus.rx_data == sum_q) ? StDone : StError;
                else if (timed_out) state_d = StError;
            end
`endif
            StDone, StError: begin
                if (clr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake/status outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rx_ready_q  <= 1'b1;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
            words_q     <= '0;
            tmo_q       <= '0;
            addr_q      <= BASE_ADDR;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= state_d inside {StIdle, StLen, StData, StCsum};
            mem_valid_q <= state_d == StWrite;
            busy_q      <= state_d inside {StLen, StData, StWrite, StCsum};
            done_q      <= state_d == StDone;
            error_q     <= state_d == StError;
            if (pk_clear) begin
                count_q <= '0;
                words_q <= '0;
                addr_q  <= BASE_ADDR;
            end
            if ((state_q == StLen) && pk_full) count_q <= pk_next;
            if ((state_q == StWrite) && bus.mem_ready) begin
                words_q <= words_q + 32'd1;
                addr_q  <= addr_q + ADDR_WIDTH'(4);
            end
            // Memory stalls in WRITE are not line faults, so the idle timer only runs on rx.
            if (accept || !counting) tmo_q <= '0;
            else                     tmo_q <= tmo_q + 32'd1;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = pk_word;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a write scoreboard fed as payload is sent.
// Checksum bytes are sent only when UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned TMO  = 200;
    localparam int unsigned MAXW = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy, done, error;
    logic [31:0] words_written;

    int total = 0;
    int passed = 0;
    int stall_len = 0;
    int stall_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] payload [4] = '{32'h44332211, 32'h88776655, 32'hCAFEF00D, 32'h0BADBEEF};

    uart_loader_if #(.ADDR_WIDTH(32)) bif ();

    uart_loader #(
        .ADDR_WIDTH     (32),
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bif),
        .clr           (clr),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Memory side: hold mem_ready low for stall_len cycles of each write request.
    always @(posedge clk) begin
        #1;
        if (bif.mem_valid) begin
            if (stall_cnt < stall_len) begin
                bif.mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                bif.mem_ready = 1'b1;
            end
        end else begin
            stall_cnt = 0;
            bif.mem_ready = (stall_len == 0);
        end
    end

    // Every cycle of a write request is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bif.mem_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bif.mem_valid), 64'd0);
            end else begin
                check("wr_addr", 64'(bif.mem_addr), 64'(exp_q[0][63:32]));
                check("wr_data", 64'(bif.mem_wdata), 64'(exp_q[0][31:0]));
                check("rx_ready_in_write", 64'(bif.rx_ready), 64'd0);
                if (bif.mem_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        @(negedge clk);
        while (!bif.rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bif.rx_ready) check("rx_accept_wait", 64'(bif.rx_ready), 64'd1);
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] cnt, output logic [7:0] sum);
        sum = '0;
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            send_byte(cnt[8*i +: 8]);
            sum = sum + cnt[8*i +: 8];
        end
    endtask

    task automatic send_words(input int first, input int n, inout logic [7:0] sum);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = payload[first + k];
            exp_q.push_back({BASE + 32'(4 * k), w});
            for (int i = 0; i < 4; i++) begin
                send_byte(w[8*i +: 8]);
                sum = sum + w[8*i +: 8];
            end
        end
    endtask

    task automatic send_frame(input int first, input int n, input logic [7:0] csum_xor);
        logic [7:0] sum;
        send_hdr(32'(n), sum);
        send_words(first, n, sum);
        sum = sum ^ csum_xor;
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_rx_ready"}, 64'(bif.rx_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(bif.rx_ready), 64'd1);
        check({tag, "_mem_valid"}, 64'(bif.mem_valid), 64'd0);
        check({tag, "_mem_addr"}, 64'(bif.mem_addr), 64'(BASE));
        check({tag, "_mem_wdata"}, 64'(bif.mem_wdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words"}, 64'(words_written), 64'd0);
    endtask

    initial begin
        logic [7:0] sum;
        bif.rx_data  = '0;
        bif.rx_valid = 1'b0;
        #2 rst = 1'b0;
        #3 check_reset_values("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-word frame, memory always ready.
        send_frame(0, 2, 8'h00);
        wait_end();
        check("f1_done", 64'(done), 64'd1);
        check("f1_error", 64'(error), 64'd0);
        check("f1_busy", 64'(busy), 64'd0);
        check("f1_words", 64'(words_written), 64'd2);
        check("f1_sb_empty", 64'(exp_q.size()), 64'd0);
        check("f1_rx_ready", 64'(bif.rx_ready), 64'd0);
        do_clr("f1_clr");

        // Same frame with 20-cycle memory stalls.
        stall_len = 20;
        send_frame(0, 2, 8'h00);
        wait_end();
        check("f2_done", 64'(done), 64'd1);
        check("f2_words", 64'(words_written), 64'd2);
        check("f2_sb_empty", 64'(exp_q.size()), 64'd0);
        do_clr("f2_clr");
        stall_len = 0;

        // Garbage before sync is discarded; zero-count frame writes nothing.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_busy", 64'(busy), 64'd0);
        send_frame(0, 0, 8'h00);
        wait_end();
        check("f3_done", 64'(done), 64'd1);
        check("f3_words", 64'(words_written), 64'd0);
        do_clr("f3_clr");

        // Oversize count: error right after the fourth length byte.
        send_hdr(32'(MAXW + 1), sum);
        check("big_error", 64'(error), 64'd1);
        check("big_done", 64'(done), 64'd0);
        check("big_busy", 64'(busy), 64'd0);
        check("big_mem_valid", 64'(bif.mem_valid), 64'd0);
        do_clr("big_clr");

`ifdef UART_LOADER_CHECKSUM_EN
        send_frame(2, 2, 8'h5A);
        wait_end();
        check("csum_error", 64'(error), 64'd1);
        check("csum_done", 64'(done), 64'd0);
        check("csum_words", 64'(words_written), 64'd2);
        do_clr("csum_clr");
`endif

        // Stop mid-payload: error exactly TMO cycles after the last accepted byte.
        send_hdr(32'd2, sum);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_before_error", 64'(error), 64'd0);
        check("tmo_before_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        do_clr("tmo_clr");

        // Reset while a write is stalled.
        stall_len = 1000;
        send_hdr(32'd1, sum);
        send_words(3, 1, sum);
        check("rstw_mem_valid", 64'(bif.mem_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_values("rstw");
        exp_q.delete();
        stall_len = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(2, 1, 8'h00);
        wait_end();
        check("f5_done", 64'(done), 64'd1);
        check("f5_words", 64'(words_written), 64'd1);
        check("f5_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 passed, total);
        $fatal(1, "watchdog");
    end

endmodule
